// File: rtl/p2s_sched.sv
// Parallel-to-serial lane sequencer: COM sync burst, IDLE fill, and data words
// shifted out MSB first with a per-bit valid qualifier.
module p2s_sched #(
    parameter int unsigned     WIDTH       = 8,
    parameter logic [WIDTH-1:0] COM_SYMBOL  = WIDTH'(8'hBC),
    parameter logic [WIDTH-1:0] IDLE_SYMBOL = WIDTH'(8'h7C),
    parameter int unsigned     SYNC_COUNT  = 4
) (
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic             ENB,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             data_out,
    output logic             valid_out,
    output logic             sym_start,
    output logic [1:0]       state_out
);

    localparam int unsigned CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned SCW = $clog2(SYNC_COUNT + 1);

    typedef enum logic [1:0] {
        ST_DIS    = 2'b00,
        ST_SYNC   = 2'b01,
        ST_ACTIVE = 2'b10
    } state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [SCW-1:0]   sync_cnt, sync_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic             dout_nx, vout_nx, sstart_nx;
    logic [WIDTH-1:0] sym;
    logic             sym_valid;

    assign state_out = state;

    // State and datapath registers
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state     <= ST_SYNC;
            cnt       <= '0;
            sync_cnt  <= '0;
            shreg     <= '0;
            data_out  <= 1'b0;
            valid_out <= 1'b0;
            sym_start <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            sync_cnt  <= sync_nx;
            shreg     <= shreg_nx;
            data_out  <= dout_nx;
            valid_out <= vout_nx;
            sym_start <= sstart_nx;
        end
    end

    // Next-state, symbol selection and shifter
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        sync_nx   = sync_cnt;
        shreg_nx  = shreg;
        dout_nx   = data_out;
        vout_nx   = valid_out;
        sstart_nx = 1'b0;
        sym       = COM_SYMBOL;
        sym_valid = 1'b0;
        ready_out = ENB && (state == ST_ACTIVE) && (cnt == '0);

        if (!ENB) begin
            state_nx = ST_DIS;
            cnt_nx   = '0;
            sync_nx  = '0;
            shreg_nx = '0;
            dout_nx  = 1'b0;
            vout_nx  = 1'b0;
        end else begin
            cnt_nx = CW'(cnt + CW'(1));
            if (cnt == '0) begin
                if (state == ST_ACTIVE) begin
                    if (valid_in) begin
                        sym       = data_in;
                        sym_valid = 1'b1;
                    end else begin
                        sym = IDLE_SYMBOL;
                    end
                end else begin
                    // DIS re-entry and SYNC both emit COM on this edge
                    state_nx = ST_SYNC;
                    if (sync_cnt != SCW'(SYNC_COUNT))
                        sync_nx = SCW'(sync_cnt + SCW'(1));
                end
                shreg_nx  = {sym[WIDTH-2:0], 1'b0};
                dout_nx   = sym[WIDTH-1];
                vout_nx   = sym_valid;
                sstart_nx = 1'b1;
            end else begin
                dout_nx  = shreg[WIDTH-1];
                shreg_nx = {shreg[WIDTH-2:0], 1'b0};
                // Go ACTIVE once the last COM has fully left the shifter
                if (state == ST_SYNC && cnt == CW'(WIDTH - 1) &&
                    sync_cnt == SCW'(SYNC_COUNT))
                    state_nx = ST_ACTIVE;
            end
        end
    end

endmodule

// File: tb/tb_p2s_sched.sv
// Bench for p2s_sched: queue-based bit-stream reference model plus directed
// and randomized scenarios.
module tb_p2s_sched;

    localparam int W  = 8;
    localparam int SC = 4;
    localparam logic [7:0] COM  = 8'hBC;
    localparam logic [7:0] IDLE = 8'h7C;

    logic       CLK, RESET_L, ENB, valid_in;
    logic [7:0] data_in;
    logic       ready_out, data_out, valid_out, sym_start;
    logic [1:0] state_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct packed {
        logic d;
        logic v;
        logic s;
    } obit_t;

    obit_t      mq[$];
    int         coms;
    int         mode;
    logic       e_d, e_v, e_s, e_rdy, last_acc;
    logic [1:0] e_st;

    p2s_sched #(
        .WIDTH(W), .COM_SYMBOL(COM), .IDLE_SYMBOL(IDLE), .SYNC_COUNT(SC)
    ) dut (
        .CLK(CLK), .RESET_L(RESET_L), .ENB(ENB),
        .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
        .data_out(data_out), .valid_out(valid_out), .sym_start(sym_start),
        .state_out(state_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic model_reset();
        mq.delete();
        coms = 0; mode = 1;
        e_d = 0; e_v = 0; e_s = 0; e_st = 2'b01; e_rdy = 0; last_acc = 0;
    endtask

    // Whole symbols are queued as bit tuples; each edge pops one
    task automatic step();
        logic       acc;
        obit_t      b;
        logic [7:0] sym;
        logic       v;
        acc = 0; sym = COM; v = 0;
        if (RESET_L !== 1'b0) begin
            if (!ENB) begin
                mq.delete();
                coms = 0; mode = 0;
                e_d = 0; e_v = 0; e_s = 0;
            end else begin
                if (mq.size() == 0) begin
                    if (mode != 2) begin
                        sym = COM; coms++; mode = 1;
                    end else if (valid_in) begin
                        sym = data_in; v = 1; acc = 1;
                    end else begin
                        sym = IDLE;
                    end
                    for (int i = W - 1; i >= 0; i--) begin
                        b.d = sym[i]; b.v = v; b.s = (i == W - 1);
                        mq.push_back(b);
                    end
                end
                b = mq.pop_front();
                e_d = b.d; e_v = b.v; e_s = b.s;
                if (mode == 1 && coms >= SC && mq.size() == 0) mode = 2;
            end
        end
        last_acc = acc;
        @(posedge CLK); #1;
        cyc++;
        e_st  = 2'(mode);
        e_rdy = (RESET_L === 1'b1) && ENB && (mode == 2) && (mq.size() == 0);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!e_rdy && n < 40) begin
            step(); n++;
            total++;
            if ({data_out, valid_out, sym_start, state_out, ready_out} !== {e_d, e_v, e_s, e_st, e_rdy}) begin
                bad++;
                $display("FAIL wait_model cyc=%0d got=%b want=%b", cyc,
                         {data_out, valid_out, sym_start, state_out, ready_out}, {e_d, e_v, e_s, e_st, e_rdy});
            end
        end
        total++;
        if (ready_out !== 1'b1) begin
            bad++;
            $display("FAIL wait_ready cyc=%0d ready_out=%b want=1", cyc, ready_out);
        end
    endtask

    task automatic test_reset();
        RESET_L = 1'b0; ENB = 1'b1; valid_in = 1'b0; data_in = '0;
        model_reset();
        repeat (3) begin
            step();
            total++;
            if ({data_out, valid_out, sym_start, state_out, ready_out} !== 6'b000010) begin
                bad++;
                $display("FAIL reset cyc=%0d got=%b want=000010", cyc,
                         {data_out, valid_out, sym_start, state_out, ready_out});
            end
        end
    endtask

    task automatic test_sync();
        logic [7:0] pat;
        pat = COM;
        @(negedge CLK) RESET_L = 1'b1;
        for (int i = 1; i <= 48; i++) begin
            step();
            total++;
            if ({data_out, valid_out, sym_start, state_out, ready_out} !== {e_d, e_v, e_s, e_st, e_rdy}) begin
                bad++;
                $display("FAIL sync_model cyc=%0d got=%b want=%b", cyc,
                         {data_out, valid_out, sym_start, state_out, ready_out}, {e_d, e_v, e_s, e_st, e_rdy});
            end
            if (i <= 32) begin
                total++;
                if (data_out !== pat[7 - ((i - 1) % 8)] || sym_start !== (((i - 1) % 8) == 0) ||
                    valid_out !== 1'b0 || ready_out !== (i == 32)) begin
                    bad++;
                    $display("FAIL sync_com i=%0d d=%b s=%b v=%b r=%b", i, data_out, sym_start, valid_out, ready_out);
                end
            end
            if (i <= 31) begin
                total++;
                if (state_out !== 2'b01) begin
                    bad++;
                    $display("FAIL sync_state i=%0d state_out=%b want=01", i, state_out);
                end
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] pat;
        pat = 8'hA5;
        wait_ready();
        valid_in = 1'b1; data_in = pat;
        step();
        valid_in = 1'b0; data_in = '0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            total++;
            if (data_out !== pat[7 - i] || valid_out !== 1'b1 ||
                {data_out, valid_out, sym_start, state_out, ready_out} !== {e_d, e_v, e_s, e_st, e_rdy}) begin
                bad++;
                $display("FAIL single i=%0d d=%b v=%b want d=%b v=1", i, data_out, valid_out, pat[7 - i]);
            end
        end
        step();
        total++;
        if (valid_out !== 1'b0 || data_out !== 1'b0 || sym_start !== 1'b1) begin
            bad++;
            $display("FAIL single_idle d=%b v=%b s=%b want 0 0 1", data_out, valid_out, sym_start);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] pat;
        pat = 16'h01FF;
        wait_ready();
        valid_in = 1'b1; data_in = 8'h01;
        for (int i = 0; i < 16; i++) begin
            step();
            total++;
            if (data_out !== pat[15 - i] || valid_out !== 1'b1 || ready_out !== (i == 7 || i == 15) ||
                {data_out, valid_out, sym_start, state_out, ready_out} !== {e_d, e_v, e_s, e_st, e_rdy}) begin
                bad++;
                $display("FAIL b2b i=%0d d=%b v=%b r=%b want d=%b v=1", i, data_out, valid_out, ready_out, pat[15 - i]);
            end
            if (last_acc && data_in == 8'h01) data_in = 8'hFF;
            else if (last_acc) valid_in = 1'b0;
        end
    endtask

    task automatic test_midsym();
        int n;
        logic [7:0] pat;
        pat = 8'h3C;
        wait_ready();
        repeat (3) step();
        valid_in = 1'b1; data_in = pat;
        n = 0;
        while (n < 20) begin
            step(); n++;
            total++;
            if ({data_out, valid_out, sym_start, state_out, ready_out} !== {e_d, e_v, e_s, e_st, e_rdy}) begin
                bad++;
                $display("FAIL mid_model cyc=%0d got=%b want=%b", cyc,
                         {data_out, valid_out, sym_start, state_out, ready_out}, {e_d, e_v, e_s, e_st, e_rdy});
            end
            if (last_acc) break;
        end
        valid_in = 1'b0; data_in = '0;
        total++;
        if (n != 6) begin
            bad++;
            $display("FAIL mid_accept_edge n=%0d want=6", n);
        end
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            total++;
            if (data_out !== pat[7 - i] || valid_out !== 1'b1) begin
                bad++;
                $display("FAIL mid_bits i=%0d d=%b v=%b want d=%b v=1", i, data_out, valid_out, pat[7 - i]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            step();
            total++;
            if (valid_out !== 1'b0 || data_out !== e_d) begin
                bad++;
                $display("FAIL mid_once i=%0d v=%b d=%b want v=0 d=%b", i, valid_out, data_out, e_d);
            end
        end
    endtask

    task automatic test_enb_drop();
        int n;
        wait_ready();
        valid_in = 1'b1; data_in = 8'hF0;
        step();
        valid_in = 1'b0;
        repeat (3) step();
        ENB = 1'b0;
        repeat (3) begin
            step();
            total++;
            if ({data_out, valid_out, sym_start, state_out, ready_out} !== 6'b000000) begin
                bad++;
                $display("FAIL enb_dis cyc=%0d got=%b want=000000", cyc,
                         {data_out, valid_out, sym_start, state_out, ready_out});
            end
        end
        ENB = 1'b1; valid_in = 1'b1; data_in = 8'h5A;
        n = 0;
        while (n < 40) begin
            total++;
            if (ready_out !== (n == 32) || valid_out !== 1'b0 ||
                (n > 0 && {data_out, sym_start, state_out} !== {e_d, e_s, e_st})) begin
                bad++;
                $display("FAIL enb_resync n=%0d r=%b v=%b d=%b st=%b", n, ready_out, valid_out, data_out, state_out);
            end
            step(); n++;
            if (last_acc) break;
        end
        valid_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++;
            if ({data_out, valid_out, sym_start, state_out, ready_out} !== {e_d, e_v, e_s, e_st, e_rdy} ||
                valid_out !== 1'b1) begin
                bad++;
                $display("FAIL enb_data i=%0d got=%b want=%b", i,
                         {data_out, valid_out, sym_start, state_out, ready_out}, {e_d, e_v, e_s, e_st, e_rdy});
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        wait_ready();
        valid_in = 1'b1; data_in = 8'hC3;
        step();
        valid_in = 1'b0;
        step(); step();
        #3 RESET_L = 1'b0;
        #1;
        total++;
        if ({data_out, valid_out, sym_start, state_out, ready_out} !== 6'b000010) begin
            bad++;
            $display("FAIL rst_async got=%b want=000010", {data_out, valid_out, sym_start, state_out, ready_out});
        end
        model_reset();
        step();
        @(negedge CLK) RESET_L = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            total++;
            if ({data_out, valid_out, sym_start, state_out, ready_out} !== {e_d, e_v, e_s, e_st, e_rdy} ||
                (i == 1 && {data_out, sym_start, state_out} !== 4'b1101)) begin
                bad++;
                $display("FAIL rst_resync i=%0d got=%b want=%b", i,
                         {data_out, valid_out, sym_start, state_out, ready_out}, {e_d, e_v, e_s, e_st, e_rdy});
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if (ENB && ($urandom % 60) == 0) ENB = 1'b0;
            else if (!ENB && ($urandom % 4) == 0) ENB = 1'b1;
            if (!valid_in && ($urandom % 3) == 0) begin
                valid_in = 1'b1; data_in = 8'($urandom);
            end
            step();
            total++;
            if ({data_out, valid_out, sym_start, state_out, ready_out} !== {e_d, e_v, e_s, e_st, e_rdy}) begin
                bad++;
                $display("FAIL random cyc=%0d got=%b want=%b", cyc,
                         {data_out, valid_out, sym_start, state_out, ready_out}, {e_d, e_v, e_s, e_st, e_rdy});
            end
            if (last_acc) valid_in = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_sync();
        test_single();
        test_back_to_back();
        test_midsym();
        test_enb_drop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
